// File: rtl/ace_video_fetch_if.sv
// Read-port bundle between the video fetcher and the screen/charset RAMs.
// Both RAMs return data one clk edge after the address is presented.
interface ace_video_fetch_if;
  logic [9:0] screen_addr;
  logic [7:0] screen_data;
  logic [9:0] char_addr;
  logic [7:0] char_data;

  modport master (output screen_addr, output char_addr, input screen_data, input char_data);
  modport slave  (input screen_addr, input char_addr, output screen_data, output char_data);
endinterface

// File: rtl/ace_video_fetch.sv
// Jupiter Ace video fetch: raster counters, screen/charset address generation,
// 1-bit pixel serialiser, sync/blank and Z80 frame interrupt, all gated by pix_ce.
module ace_video_fetch #(
  parameter int H_TOTAL     = 416,
  parameter int V_TOTAL     = 312,
  parameter int HSYNC_START = 320,
  parameter int HSYNC_LEN   = 32,
  parameter int VSYNC_START = 248,
  parameter int VSYNC_LEN   = 8,
  parameter int INT_LEN     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  ace_video_fetch_if.master mem,
  output logic              pixel,
  output logic              blank,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              int_n,
  output logic [8:0]        hc,
  output logic [8:0]        vc
);
  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
  localparam logic [8:0] HS_BEG  = 9'(HSYNC_START);
  localparam logic [8:0] HS_END  = 9'(HSYNC_START + HSYNC_LEN);
  localparam logic [8:0] VS_BEG  = 9'(VSYNC_START);
  localparam logic [8:0] VS_END  = 9'(VSYNC_START + VSYNC_LEN);
  localparam logic [8:0] INT_END = 9'(INT_LEN);

  logic [8:0] hc_q, hc_d, vc_q, vc_d;
  logic [9:0] saddr_q, saddr_d;
  logic [7:0] code_q, code_d;
  logic [2:0] crow_q, crow_d;
  logic [7:0] pat_q, pat_d;
  logic [7:0] shift_q, shift_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d, vs_q, vs_d, int_q, int_d;
  logic       fetch_en;

  assign fetch_en = (hc_q < 9'd256) && (vc_q < 9'd192);

  always_comb begin
    hc_d    = hc_q;
    vc_d    = vc_q;
    saddr_d = saddr_q;
    code_d  = code_q;
    crow_d  = crow_q;
    pat_d   = pat_q;
    shift_d = shift_q;
    blank_d = blank_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    int_d   = int_q;
    if (pix_ce) begin
      if (hc_q == H_LAST) begin
        hc_d = 9'd0;
        vc_d = (vc_q == V_LAST) ? 9'd0 : vc_q + 9'd1;
      end else begin
        hc_d = hc_q + 9'd1;
      end
      shift_d = {shift_q[6:0], 1'b0};
      // Each 8-tick cell: address screen, then charset, then load the shifter
      // so the pattern leaves exactly 8 ticks after its screen fetch began.
      if (fetch_en) begin
        case (hc_q[2:0])
          3'd0: saddr_d = {vc_q[7:3], hc_q[7:3]};
          3'd2: begin
            code_d = mem.screen_data;
            crow_d = vc_q[2:0];
          end
          3'd4: pat_d = mem.char_data;
          3'd7: shift_d = pat_q ^ {8{code_q[7]}};
          default: ;
        endcase
      end
      // Timing outputs are decoded from the next counter values so they
      // line up with hc/vc on the tick they describe.
      blank_d = !((hc_d >= 9'd8) && (hc_d <= 9'd263) && (vc_d < 9'd192));
      hs_d    = !((hc_d >= HS_BEG) && (hc_d < HS_END));
      vs_d    = !((vc_d >= VS_BEG) && (vc_d < VS_END));
      int_d   = !((vc_d == VS_BEG) && (hc_d < INT_END));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q    <= '0;
      vc_q    <= '0;
      saddr_q <= '0;
      code_q  <= '0;
      crow_q  <= '0;
      pat_q   <= '0;
      shift_q <= '0;
      blank_q <= 1'b1;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      int_q   <= 1'b1;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      saddr_q <= saddr_d;
      code_q  <= code_d;
      crow_q  <= crow_d;
      pat_q   <= pat_d;
      shift_q <= shift_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      int_q   <= int_d;
    end
  end

  assign mem.screen_addr = saddr_q;
  assign mem.char_addr   = {code_q[6:0], crow_q};
  assign pixel           = shift_q[7] & ~blank_q;
  assign blank           = blank_q;
  assign hsync_n         = hs_q;
  assign vsync_n         = vs_q;
  assign int_n           = int_q;
  assign hc              = hc_q;
  assign vc              = vc_q;
endmodule

// File: tb/tb_ace_video_fetch.sv
// Directed bench for ace_video_fetch; a shortened raster keeps a full frame
// affordable while leaving the 256x192 window and fetch schedule untouched.
module tb_ace_video_fetch;
  localparam int HT = 272, VT = 196, HSS = 264, HSL = 4, VSS = 193, VSL = 2, IL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_ce = 1'b0;
  logic       pixel, blank, hsync_n, vsync_n, int_n;
  logic [8:0] hc, vc;
  logic [7:0] sram [1024];
  logic [7:0] cram [1024];
  logic       ref_pix [301];
  int         total = 0;
  int         bad = 0;

  ace_video_fetch_if bus ();

  ace_video_fetch #(
    .H_TOTAL(HT), .V_TOTAL(VT), .HSYNC_START(HSS), .HSYNC_LEN(HSL),
    .VSYNC_START(VSS), .VSYNC_LEN(VSL), .INT_LEN(IL)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .mem(bus),
    .pixel(pixel), .blank(blank), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .int_n(int_n), .hc(hc), .vc(vc)
  );

  always #5 clk = ~clk;

  // Registered-output RAM models: data follows the address by one clk edge.
  always @(posedge clk) begin
    bus.screen_data <= sram[bus.screen_addr];
    bus.char_data   <= cram[bus.char_addr];
  end

  task automatic step(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ce);
    rst = 1'b1;
    step(ce);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
    total++; if (hc !== 9'd0 || vc !== 9'd0) begin bad++; $display("FAIL reset_counters hc=%0d vc=%0d exp 0/0", hc, vc); end
    total++; if ({pixel, blank} !== 2'b01) begin bad++; $display("FAIL reset_pix_blank got=%b exp=01", {pixel, blank}); end
    total++; if ({hsync_n, vsync_n, int_n} !== 3'b111) begin bad++; $display("FAIL reset_syncs got=%b exp=111", {hsync_n, vsync_n, int_n}); end
    total++; if (bus.screen_addr !== 10'd0 || bus.char_addr !== 10'd0) begin bad++; $display("FAIL reset_addr sa=%h ca=%h exp 0/0", bus.screen_addr, bus.char_addr); end
  endtask

  task automatic test_inverse;
    logic [7:0] c0, c1, c31, l1;
    logic [3:0] bl;
    c0 = '0; c1 = '0; c31 = '0; l1 = '0; bl = '0;
    sram[0] = 8'h81; sram[1] = 8'h02; sram[31] = 8'h83;
    cram[8] = 8'hF0; cram[16] = 8'hA5; cram[24] = 8'h3C; cram[9] = 8'h81;
    do_reset(1'b1);
    ref_pix[0] = pixel;
    for (int k = 1; k <= 300; k++) begin
      step(1'b1);
      ref_pix[k] = pixel;
      if (k >= 8 && k <= 15)    c0  = {c0[6:0], pixel};
      if (k >= 16 && k <= 23)   c1  = {c1[6:0], pixel};
      if (k >= 256 && k <= 263) c31 = {c31[6:0], pixel};
      if (k >= 280 && k <= 287) l1  = {l1[6:0], pixel};
      if (k == 7)   bl[3] = blank;
      if (k == 8)   bl[2] = blank;
      if (k == 263) bl[1] = blank;
      if (k == 264) bl[0] = blank;
    end
    total++; if (c0 !== 8'h0F)  begin bad++; $display("FAIL inverse_cell0 got=%h exp=0f", c0); end
    total++; if (c1 !== 8'hA5)  begin bad++; $display("FAIL normal_cell1 got=%h exp=a5", c1); end
    total++; if (c31 !== 8'hC3) begin bad++; $display("FAIL last_col got=%h exp=c3", c31); end
    total++; if (l1 !== 8'h7E)  begin bad++; $display("FAIL line1_row_select got=%h exp=7e", l1); end
    total++; if (bl !== 4'b1001) begin bad++; $display("FAIL blank_edges got=%b exp=1001", bl); end
  endtask

  task automatic test_pix_ce_gating;
    int cnt, hc_err, pix_err;
    logic [3:0] pat;
    cnt = 0; hc_err = 0; pix_err = 0; pat = 4'b1001;
    do_reset(1'b1);
    for (int s = 0; s < 600; s++) begin
      logic ce;
      ce = pat[3 - (s % 4)];
      step(ce);
      if (ce) cnt++;
      if (hc !== 9'(cnt % HT)) hc_err++;
      if (pixel !== ref_pix[cnt]) pix_err++;
    end
    total++; if (hc_err != 0)  begin bad++; $display("FAIL gate_hc errors=%0d exp=0", hc_err); end
    total++; if (pix_err != 0) begin bad++; $display("FAIL gate_pixel errors=%0d exp=0", pix_err); end
    total++; if (hc !== 9'd28 || vc !== 9'd1) begin bad++; $display("FAIL gate_end hc=%0d vc=%0d exp 28/1", hc, vc); end
  endtask

  task automatic test_address;
    sram[10'h025] = 8'h41;
    do_reset(1'b1);
    for (int k = 0; k < 9 * HT + 40; k++) step(1'b1);
    total++; if (hc !== 9'd40 || vc !== 9'd9) begin bad++; $display("FAIL addr_pos hc=%0d vc=%0d exp 40/9", hc, vc); end
    total++; if (bus.screen_addr !== 10'h024) begin bad++; $display("FAIL addr_prev got=%h exp=024", bus.screen_addr); end
    step(1'b1);
    total++; if (bus.screen_addr !== 10'h025) begin bad++; $display("FAIL addr_row1col5 got=%h exp=025", bus.screen_addr); end
    step(1'b1);
    total++; if (bus.char_addr !== 10'h001) begin bad++; $display("FAIL char_addr_prev got=%h exp=001", bus.char_addr); end
    step(1'b1);
    total++; if (bus.char_addr !== 10'h209) begin bad++; $display("FAIL char_addr got=%h exp=209", bus.char_addr); end
    for (int k = 0; k < 5; k++) step(1'b1);
    total++; if (bus.screen_addr !== 10'h025) begin bad++; $display("FAIL addr_hold got=%h exp=025", bus.screen_addr); end
    step(1'b1);
    total++; if (bus.screen_addr !== 10'h026) begin bad++; $display("FAIL addr_next got=%h exp=026", bus.screen_addr); end
  endtask

  task automatic test_mid_reset;
    int budget;
    logic [7:0] c0;
    budget = 20000; c0 = '0;
    while (!(hc == 9'd130 && vc == 9'd60) && budget > 0) begin
      step(1'b1);
      budget--;
    end
    total++; if (budget == 0) begin bad++; $display("FAIL midrst_reach hc=%0d vc=%0d exp 130/60", hc, vc); end
    total++; if (blank !== 1'b0) begin bad++; $display("FAIL midrst_window blank=%b exp=0", blank); end
    sram[0] = 8'h01;
    do_reset(1'b0);
    total++; if (hc !== 9'd0 || vc !== 9'd0 || blank !== 1'b1) begin bad++; $display("FAIL midrst_state hc=%0d vc=%0d blank=%b exp 0/0/1", hc, vc, blank); end
    total++; if (bus.screen_addr !== 10'd0) begin bad++; $display("FAIL midrst_addr got=%h exp=000", bus.screen_addr); end
    for (int k = 1; k <= 15; k++) begin
      step(1'b1);
      if (k >= 8) c0 = {c0[6:0], pixel};
    end
    total++; if (c0 !== 8'hF0) begin bad++; $display("FAIL midrst_cell0 got=%h exp=f0", c0); end
  endtask

  task automatic test_frame;
    int mh, mv, pos_err, blk_err, sync_err, blk_lo, hs_lo, vs_lo, int_lo;
    logic eb, ehs, evs, ei;
    mh = 0; mv = 0; pos_err = 0; blk_err = 0; sync_err = 0;
    blk_lo = 0; hs_lo = 0; vs_lo = 0; int_lo = 0;
    do_reset(1'b1);
    for (int t = 0; t < HT * VT; t++) begin
      step(1'b1);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh++;
      eb  = !(mh >= 8 && mh <= 263 && mv < 192);
      ehs = !(mh >= HSS && mh < HSS + HSL);
      evs = !(mv >= VSS && mv < VSS + VSL);
      ei  = !(mv == VSS && mh < IL);
      if (hc !== 9'(mh) || vc !== 9'(mv)) pos_err++;
      if (blank !== eb) blk_err++;
      if ({hsync_n, vsync_n, int_n} !== {ehs, evs, ei}) begin
        if (sync_err == 0) $display("FAIL frame_sync_first mh=%0d mv=%0d got=%b exp=%b", mh, mv, {hsync_n, vsync_n, int_n}, {ehs, evs, ei});
        sync_err++;
      end
      if (!blank)   blk_lo++;
      if (!hsync_n) hs_lo++;
      if (!vsync_n) vs_lo++;
      if (!int_n)   int_lo++;
    end
    total++; if (pos_err != 0)  begin bad++; $display("FAIL frame_counters errors=%0d exp=0", pos_err); end
    total++; if (blk_err != 0)  begin bad++; $display("FAIL frame_blank_pos errors=%0d exp=0", blk_err); end
    total++; if (sync_err != 0) begin bad++; $display("FAIL frame_sync_pos errors=%0d exp=0", sync_err); end
    total++; if (blk_lo != 49152) begin bad++; $display("FAIL frame_active got=%0d exp=49152", blk_lo); end
    total++; if (hs_lo != HSL * VT) begin bad++; $display("FAIL frame_hsync got=%0d exp=%0d", hs_lo, HSL * VT); end
    total++; if (vs_lo != VSL * HT) begin bad++; $display("FAIL frame_vsync got=%0d exp=%0d", vs_lo, VSL * HT); end
    total++; if (int_lo != IL) begin bad++; $display("FAIL frame_int got=%0d exp=%0d", int_lo, IL); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 8'h00;
      cram[i] = 8'h00;
    end
    @(negedge clk);
    test_reset();
    test_inverse();
    test_pix_ce_gating();
    test_address();
    test_mid_reset();
    test_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
